// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : song_pkg
//  Description : Shared types and constants for the song sequencer: FSM state
//                encoding, special note codes and octave-3 half-period table.
//  Revision    : 1.0 - initial release
// ============================================================================
package song_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned NOTE_REST = 0;
    localparam int unsigned NOTE_END  = 63;
    localparam int unsigned NOTE_MAX  = 36;

    // Half-period counts (50 MHz clock) for C3..B3; lower octaves shift left.
    localparam int unsigned BASE3 [12] = '{
        191110, 180388, 170264, 160705, 151685, 143172,
        135139, 127551, 120395, 113636, 107259, 101239
    };

    // True for codes that map to a pitched note (C1..B3).
    function automatic logic is_pitched(input int unsigned code);
        return (code >= 1) && (code <= NOTE_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : song_sequencer_if
//  Description : Host-side control, song-RAM write port and tone-generator
//                outputs of the song sequencer, grouped as one bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface song_sequencer_if #(
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 4,
    parameter int NOTE_W   = 6,
    parameter int PERIOD_W = 20
);
    logic                    start;
    logic                    stop;
    logic                    loop_en;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [NOTE_W+DUR_W-1:0] wr_data;
    logic [NOTE_W-1:0]       note_code;
    logic [PERIOD_W-1:0]     period;
    logic                    note_on;
    logic [ADDR_W-1:0]       step_addr;
    logic                    busy;
    logic                    song_done;

    modport master (
        output start, stop, loop_en, wr_en, wr_addr, wr_data,
        input  note_code, period, note_on, step_addr, busy, song_done
    );

    modport slave (
        input  start, stop, loop_en, wr_en, wr_addr, wr_data,
        output note_code, period, note_on, step_addr, busy, song_done
    );
endinterface
`default_nettype wire

// File: rtl/note_period_lut.sv
`default_nettype none
// ============================================================================
//  Module      : note_period_lut
//  Description : Combinational note code -> tone half-period mapping.
//                Codes outside C1..B3 give 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_period_lut
    import song_pkg::*;
#(
    parameter int NOTE_W   = 6,
    parameter int PERIOD_W = 20
) (
    input  wire logic [NOTE_W-1:0]   code,
    output logic      [PERIOD_W-1:0] period
);

    logic [NOTE_W-1:0] w_idx;
    logic [1:0]        w_oct;
    logic [3:0]        w_semi;

    // Split the code into octave and semitone, then scale the octave-3 entry.
    always_comb begin
        w_idx  = '0;
        w_oct  = '0;
        w_semi = '0;
        period = '0;
        if (is_pitched(32'(code))) begin
            w_idx  = code - NOTE_W'(1);
            w_oct  = 2'(w_idx / NOTE_W'(12));   // 0..2 for octaves 1..3
            w_semi = 4'(w_idx % NOTE_W'(12));
            period = PERIOD_W'(BASE3[w_semi] << (2'd2 - w_oct));
        end
    end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : song_sequencer
//  Description : Plays a song from a writable internal RAM. Each entry holds
//                {note_code, duration}; the sequencer presents the note and
//                its half-period to the tone generator for (d+1) beat ticks.
//                Supports start/stop, looping, end marker and articulation.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_sequencer
    import song_pkg::*;
#(
    parameter int TICK_DIV = 6250000,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 4,
    parameter int NOTE_W   = 6,
    parameter int PERIOD_W = 20,
    parameter bit ARTIC    = 1'b1
) (
    input wire logic     clk50,
    input wire logic     reset,
    song_sequencer_if.slave bus
);

    localparam int                c_CNT_W = $clog2(TICK_DIV);
    localparam int                c_DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST  = {ADDR_W{1'b1}};

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       w_addr_nxt;
    logic                    w_addr_set;
    logic                    w_latch;
    logic                    w_clear;
    logic                    w_dec;

    logic [NOTE_W+DUR_W-1:0] r_mem [c_DEPTH];
    logic [NOTE_W+DUR_W-1:0] r_rd_data;
    logic [NOTE_W-1:0]       w_rd_code;
    logic [DUR_W-1:0]        w_rd_dur;
    logic                    w_pitched;
    logic [PERIOD_W-1:0]     w_lut_period;

    logic [c_CNT_W-1:0]      r_tick_cnt;
    logic                    w_tick;
    logic [DUR_W-1:0]        r_dur_cnt;

    logic [NOTE_W-1:0]       r_note_code;
    logic [PERIOD_W-1:0]     r_period;
    logic                    r_note_on;
    logic [ADDR_W-1:0]       r_step_addr;

    assign w_rd_code = r_rd_data[NOTE_W+DUR_W-1:DUR_W];
    assign w_rd_dur  = r_rd_data[DUR_W-1:0];
    assign w_pitched = is_pitched(32'(w_rd_code));
    assign w_tick    = (r_state == ST_HOLD) && (r_tick_cnt == c_CNT_W'(TICK_DIV - 1));

    note_period_lut #(
        .NOTE_W   (NOTE_W),
        .PERIOD_W (PERIOD_W)
    ) u_lut (
        .code   (w_rd_code),
        .period (w_lut_period)
    );

    // Song RAM: write port always open, read registered from the fetch address.
    always_ff @(posedge clk50) begin
        if (bus.wr_en) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end
        r_rd_data <= r_mem[r_addr];
    end

    // FSM state register.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and control strobes; stop overrides start, start overrides play.
    always_comb begin
        w_next     = r_state;
        w_addr_set = 1'b0;
        w_addr_nxt = '0;
        w_latch    = 1'b0;
        w_clear    = 1'b0;
        w_dec      = 1'b0;
        if (bus.stop) begin
            w_next  = ST_IDLE;
            w_clear = 1'b1;
        end else if (bus.start) begin
            w_next     = ST_FETCH;
            w_addr_set = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next = ST_IDLE;
                end
                ST_FETCH: begin
                    w_next = ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_rd_code == NOTE_W'(NOTE_END)) begin
                        if (bus.loop_en) begin
                            w_next     = ST_FETCH;
                            w_addr_set = 1'b1;
                        end else begin
                            w_next  = ST_DONE;
                            w_clear = 1'b1;
                        end
                    end else begin
                        w_next  = ST_HOLD;
                        w_latch = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (r_dur_cnt != '0) begin
                            w_dec = 1'b1;
                        end else if (r_addr != c_LAST) begin
                            w_next     = ST_FETCH;
                            w_addr_set = 1'b1;
                            w_addr_nxt = r_addr + ADDR_W'(1);
                        end else if (bus.loop_en) begin
                            w_next     = ST_FETCH;
                            w_addr_set = 1'b1;
                        end else begin
                            w_next  = ST_DONE;
                            w_clear = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_next = ST_IDLE;
                end
                default: begin
                    w_next  = ST_IDLE;
                    w_clear = 1'b1;
                end
            endcase
        end
    end

    // Fetch address register.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_addr_set) begin
            r_addr <= w_addr_nxt;
        end
    end

    // Beat-tick counter: runs only in HOLD, so it restarts from 0 for every note.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_HOLD) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + c_CNT_W'(1);
        end else begin
            r_tick_cnt <= '0;
        end
    end

    // Output/duration registers; held through the fetch/load gap.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_note_code <= '0;
            r_period    <= '0;
            r_note_on   <= 1'b0;
            r_step_addr <= '0;
            r_dur_cnt   <= '0;
        end else if (w_clear) begin
            r_note_code <= '0;
            r_period    <= '0;
            r_note_on   <= 1'b0;
            r_step_addr <= '0;
            r_dur_cnt   <= '0;
        end else if (w_latch) begin
            r_note_code <= w_pitched ? w_rd_code : '0;
            r_period    <= w_lut_period;
            r_step_addr <= r_addr;
            r_dur_cnt   <= w_rd_dur;
            // A zero-length note is entirely in its final tick, so it stays silent.
            r_note_on   <= w_pitched && !(ARTIC && (w_rd_dur == '0));
        end else if (w_dec) begin
            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
            if (ARTIC && (r_dur_cnt == DUR_W'(1))) begin
                r_note_on <= 1'b0;
            end
        end
    end

    assign bus.note_code = r_note_code;
    assign bus.period    = r_period;
    assign bus.note_on   = r_note_on;
    assign bus.step_addr = r_step_addr;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.song_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Programmable, parametrised successor to the fixed-song note player. Plays a song stored in an internal writable song RAM.
- Each entry carries a note code and a duration in beat ticks.
- Outputs the current note code and the tone half-period count for the downstream tone generator.
- Adds start/stop control, loop mode, an end-of-song marker, optional articulation gaps and a busy/done status. Sits between the host/keyboard control logic and the tone generator.

Parameters:
- TICK_DIV, 6250000, clk50 cycles per beat tick (8th note at 50 MHz / 240 bpm); must be >= 2.
- ADDR_W, 6, song RAM address width; depth = 2**ADDR_W entries.
- DUR_W, 4, duration field width; stored value d plays for d+1 ticks.
- NOTE_W, 6, note code width. Code 0 = rest, 1..36 = C1..B3, 63 = end marker, other codes are treated as rest.
- PERIOD_W, 20, half-period output width.
- ARTIC, 1, when 1 note_on drops during the final tick of every non-rest note.

Ports:
- clk50  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse: begin playing at address 0
- stop  in  1  1-cycle pulse: abort playback
- loop_en  in  1  1 = restart at address 0 at end of song
- wr_en  in  1  song RAM write strobe
- wr_addr  in  ADDR_W  song RAM write address
- wr_data  in  NOTE_W+DUR_W  {note_code, duration}
- note_code  out  NOTE_W  note currently sounding; 0 when silent
- period  out  PERIOD_W  half-period count for note_code; 0 for rest/silent
- note_on  out  1  gate to the tone generator
- step_addr  out  ADDR_W  address of current entry
- busy  out  1  high in any state but IDLE
- song_done  out  1  1-cycle pulse when playback ends without looping

Behaviour:
- Reset: all outputs are 0, FSM = IDLE, tick counter = 0, RAM contents undefined.
- Song RAM: synchronous write, synchronous read with 1-cycle latency.
  - A write at the current step_addr takes effect at the next fetch of that address.
  - Writes are accepted in all states.
- Tick generator: counts 0..TICK_DIV-1 while in HOLD. tick = 1 for one cycle when count = TICK_DIV-1, then the count wraps to 0. The count clears on entry to HOLD.
- FSM states: IDLE, FETCH, LOAD, HOLD, DONE.
  - IDLE: on start -> FETCH with addr = 0.
  - FETCH: drive the read address -> LOAD.
  - LOAD: data valid.
    - If code = 63 (end marker) -> loop_en ? FETCH addr 0 : DONE.
    - Otherwise latch note_code, period and step_addr, set dur_cnt = d, note_on = (code in 1..36) -> HOLD.
  - HOLD: on each tick, dur_cnt decrements. On a tick with dur_cnt = 0:
    - addr = 2**ADDR_W-1 -> loop_en ? FETCH 0 : DONE
    - otherwise -> FETCH addr+1.
  - DONE: song_done = 1 for one cycle, outputs clear -> IDLE.
- Inter-note gap: 2 cycles (FETCH, LOAD). Outputs hold their previous values during this gap.
- Articulation: with ARTIC = 1, note_on = 0 while dur_cnt = 0 in HOLD. A note with d = 0 therefore plays silent.
- stop: highest priority in every state. Next state is IDLE, all outputs clear, and no song_done pulse is issued.
- start while busy: restarts from address 0, entering FETCH next cycle. start and stop in the same cycle: stop wins.
- loop_en is sampled at the end-of-song decision point only.
- Period: for code n in 1..36, oct = (n-1)/12 + 1 and semi = (n-1)%12. period = BASE3[semi] << (3 - oct), registered in LOAD.

Decomposition:
- Package song_pkg holds:
  - FSM state enum
  - codes NOTE_REST = 0 and NOTE_END = 63
  - BASE3[0..11] octave-3 half-period constants, with C3 = 191110 and A3 = 113636.
- Sub-module note_period_lut: combinational code -> period mapping, instantiated once.

Test Plan:
- All tests run with TICK_DIV = 4.
- Reset mid-HOLD: assert reset -> all outputs 0 immediately, asynchronously; after release busy = 0.
- Load {13,1},{0,0},{63,x}; pulse start -> C2 plays with period 382220 and note_on high for 4 cycles, low for 4 cycles (ARTIC). Rest follows for 4 cycles, then song_done pulses once and busy = 0.
- Same song with loop_en = 1 -> step_addr returns to 0 after the marker; period 382220 reappears and song_done never pulses.
- Code 34 (A3), d = 2 -> period 113636, duration 12 cycles measured from the end of LOAD.
- Pulse stop mid-note -> next cycle note_on = 0, period = 0, busy = 0, no song_done.
- Fill all 2**ADDR_W entries with no marker and loop_en = 0 -> after the last entry song_done pulses. Also write address 1 while address 0 plays -> the new value is played.
